// File: rtl/micro_tile_pkg.sv
// Shared definitions for the micro tile container: controller state encoding
// and the tile count / select width also used by the container output mux.
package micro_tile_pkg;

    localparam int MT_NUM_TILES      = 4;
    localparam int MT_SEL_W          = 2;
    localparam int MT_QUIESCE_CYCLES = 4;
    localparam int MT_DWELL_W        = 16;

    typedef enum logic [2:0] {
        BOOT,
        RUN,
        DRAIN,
        GATE,
        WAKE
    } tile_ctrl_state_t;

endpackage

// File: rtl/micro_tile_dwell_timer.sv
// Loadable up-counter with clear and enable; tc is high while enabled and the
// count equals the terminal value, so the owner sees it in the last counted cycle.
module micro_tile_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] count_reg;

    assign tc = en && (count_reg == term);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en) begin
            count_reg <= count_reg + W'(1);
        end
    end

endmodule

// File: rtl/micro_tile_sel_ctrl.sv
// Tile selection controller: keeps exactly one micro tile clocked and out of reset,
// and walks every switch through drain, clock gate and wake phases.
module micro_tile_sel_ctrl
    import micro_tile_pkg::*;
#(
    parameter int NUM_TILES      = MT_NUM_TILES,
    parameter int SEL_W          = MT_SEL_W,
    parameter int QUIESCE_CYCLES = MT_QUIESCE_CYCLES,
    parameter int DWELL_W        = MT_DWELL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [SEL_W-1:0]     req_sel,
    output logic                 req_ready,
    input  logic                 auto_en,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [NUM_TILES-1:0] tile_clk_en,
    output logic [NUM_TILES-1:0] tile_rst_n,
    output logic [SEL_W-1:0]     active_sel,
    output logic                 out_valid,
    output logic                 busy
);

    localparam int CNT_W    = $clog2(QUIESCE_CYCLES + 1);
    localparam int SEL_SPAN = 2 ** SEL_W;

    tile_ctrl_state_t     state_reg;
    logic [SEL_W-1:0]     active_reg;
    logic [SEL_W-1:0]     target_reg;
    logic [NUM_TILES-1:0] clk_en_reg;
    logic [NUM_TILES-1:0] rst_n_reg;
    logic                 run_reg;

    logic [SEL_SPAN-1:0]  sel_in_range;
    logic [NUM_TILES-1:0] onehot_active;
    logic [NUM_TILES-1:0] onehot_target;
    logic [SEL_W-1:0]     auto_sel;
    logic [SEL_W-1:0]     switch_sel;
    logic                 switch_go;
    logic                 state_leave;

    logic                 phase_en;
    logic                 phase_tc;
    logic [CNT_W-1:0]     phase_term;
    logic                 dwell_en;
    logic                 dwell_tc;
    logic [DWELL_W-1:0]   dwell_term;

    // Select codes past the last tile are legal on the pins but map to nothing.
    generate
        for (genvar gi = 0; gi < SEL_SPAN; gi++) begin : g_range
            assign sel_in_range[gi] = (gi < NUM_TILES);
        end
        for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_decode
            assign onehot_active[gi] = (active_reg == SEL_W'(gi));
            assign onehot_target[gi] = (target_reg == SEL_W'(gi));
        end
    endgenerate

    assign auto_sel = (active_reg == SEL_W'(NUM_TILES - 1)) ? '0 : active_reg + SEL_W'(1);

    // An external request in RUN always wins over the auto-scan expiry, even a no-op one.
    always_comb begin
        switch_go  = 1'b0;
        switch_sel = auto_sel;
        if (state_reg == RUN) begin
            if (req_valid) begin
                switch_go  = sel_in_range[req_sel] && (req_sel != active_reg);
                switch_sel = req_sel;
            end else if (dwell_tc) begin
                switch_go = 1'b1;
            end
        end
    end

    assign state_leave = phase_tc || (state_reg == GATE) || switch_go;

    // BOOT counts one extra cycle: its first cycle is the reset-value cycle with clocks off.
    assign phase_en   = (state_reg == BOOT) || (state_reg == DRAIN) || (state_reg == WAKE);
    assign phase_term = (state_reg == BOOT) ? CNT_W'(QUIESCE_CYCLES) : CNT_W'(QUIESCE_CYCLES - 1);

    micro_tile_dwell_timer #(
        .W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_leave),
        .en       (phase_en),
        .load     (1'b0),
        .load_val ('0),
        .term     (phase_term),
        .tc       (phase_tc)
    );

    assign dwell_en   = (state_reg == RUN) && auto_en && (dwell != '0);
    assign dwell_term = dwell - DWELL_W'(1);

    // Reload to zero on expiry so a dropped auto request simply starts a fresh dwell.
    micro_tile_dwell_timer #(
        .W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (!dwell_en),
        .en       (dwell_en),
        .load     (dwell_tc),
        .load_val ('0),
        .term     (dwell_term),
        .tc       (dwell_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= BOOT;
            active_reg <= '0;
            target_reg <= '0;
            clk_en_reg <= '0;
            rst_n_reg  <= '0;
            run_reg    <= 1'b0;
        end else begin
            unique case (state_reg)
                BOOT: begin
                    clk_en_reg <= onehot_active;
                    if (phase_tc) begin
                        state_reg <= RUN;
                        rst_n_reg <= onehot_active;
                        run_reg   <= 1'b1;
                    end
                end
                RUN: begin
                    if (switch_go) begin
                        state_reg  <= DRAIN;
                        target_reg <= switch_sel;
                        rst_n_reg  <= '0;
                        run_reg    <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (phase_tc) begin
                        state_reg  <= GATE;
                        clk_en_reg <= '0;
                    end
                end
                GATE: begin
                    state_reg  <= WAKE;
                    active_reg <= target_reg;
                    clk_en_reg <= onehot_target;
                end
                WAKE: begin
                    if (phase_tc) begin
                        state_reg <= RUN;
                        rst_n_reg <= onehot_active;
                        run_reg   <= 1'b1;
                    end
                end
                default: begin
                    state_reg  <= BOOT;
                    clk_en_reg <= '0;
                    rst_n_reg  <= '0;
                    run_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign tile_clk_en = clk_en_reg;
    assign tile_rst_n  = rst_n_reg;
    assign active_sel  = active_reg;
    assign out_valid   = run_reg;
    assign req_ready   = run_reg;
    assign busy        = !run_reg;

endmodule

// File: tb/tb_micro_tile_sel_ctrl.sv
// Bench for micro_tile_sel_ctrl: a frame-queue timeline model compared every cycle,
// directed scenarios with literal expectations, then a randomised stress run.
module tb_micro_tile_sel_ctrl;

    localparam int NT = 4;
    localparam int SW = 3;
    localparam int QC = 4;
    localparam int DW = 16;

    localparam int M_RST   = 0;
    localparam int M_BOOT  = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;
    localparam int M_GATE  = 4;
    localparam int M_WAKE  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [SW-1:0] req_sel = '0;
    logic          auto_en = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic          req_ready;
    logic [NT-1:0] tile_clk_en;
    logic [NT-1:0] tile_rst_n;
    logic [SW-1:0] active_sel;
    logic          out_valid;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    micro_tile_sel_ctrl #(
        .NUM_TILES      (NT),
        .SEL_W          (SW),
        .QUIESCE_CYCLES (QC),
        .DWELL_W        (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_ready   (req_ready),
        .auto_en     (auto_en),
        .dwell       (dwell),
        .tile_clk_en (tile_clk_en),
        .tile_rst_n  (tile_rst_n),
        .active_sel  (active_sel),
        .out_valid   (out_valid),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    // Model: each cycle the controller shows one frame; a switch appends its whole timeline.
    typedef struct packed {
        logic [2:0] mode;
        logic [2:0] tile;
    } frame_t;

    frame_t fq[$];
    frame_t shown;
    int     cur;
    int     age;
    int     nxt;
    bit     tick;
    bit     model_on  = 1'b0;
    bit     rst_seen  = 1'b0;
    bit     have_prev = 1'b0;
    bit     prev_gate;
    logic [SW-1:0] prev_sel;

    function automatic frame_t mkf(input int m, input int t);
        frame_t f;
        f.mode = 3'(m);
        f.tile = 3'(t);
        return f;
    endfunction

    function automatic logic [13:0] expect_of(input frame_t f);
        logic [3:0] oh;
        logic [3:0] en;
        logic [3:0] rn;
        logic       v;
        oh = 4'b0001 << f.tile;
        en = (f.mode == 3'(M_RST) || f.mode == 3'(M_GATE)) ? 4'b0000 : oh;
        rn = (f.mode == 3'(M_RUN)) ? oh : 4'b0000;
        v  = (f.mode == 3'(M_RUN));
        return {en, rn, (f.mode == 3'(M_RST)) ? 3'b000 : f.tile, v, v, ~v};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            rst_seen = rst;
            if (rst) begin
                fq.delete();
                shown = mkf(M_RST, 0);
                for (int i = 0; i < QC; i++) fq.push_back(mkf(M_BOOT, 0));
                cur = 0;
                age = 0;
                model_on = 1'b1;
            end else if (model_on) begin
                nxt = -1;
                if (shown.mode == 3'(M_RUN)) begin
                    tick = auto_en && (dwell != 0);
                    if (req_valid) begin
                        if (int'(req_sel) < NT && int'(req_sel) != cur) nxt = int'(req_sel);
                    end else if (tick && age == int'(dwell) - 1) begin
                        nxt = (cur + 1) % NT;
                    end
                    if (nxt >= 0) begin
                        for (int i = 0; i < QC; i++) fq.push_back(mkf(M_DRAIN, cur));
                        fq.push_back(mkf(M_GATE, cur));
                        for (int i = 0; i < QC; i++) fq.push_back(mkf(M_WAKE, nxt));
                        cur = nxt;
                        age = 0;
                    end else if (tick) begin
                        age = (age == int'(dwell) - 1) ? 0 : age + 1;
                    end else begin
                        age = 0;
                    end
                end else begin
                    age = 0;
                end
                shown = (fq.size() > 0) ? fq.pop_front() : mkf(M_RUN, cur);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("model", 32'({tile_clk_en, tile_rst_n, active_sel, out_valid, req_ready, busy}),
                    32'(expect_of(shown)));
                chk("onehot_en", 32'($countones(tile_clk_en) <= 1), 32'(1));
                chk("rstn_needs_en", 32'(tile_rst_n & ~tile_clk_en), 32'(0));
                if (have_prev)
                    chk("sel_stable", 32'(active_sel == prev_sel || prev_gate || rst_seen), 32'(1));
                prev_sel  = active_sel;
                prev_gate = (tile_clk_en == '0) && busy;
                have_prev = 1'b1;
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_req(input int sel);
        req_valid = 1'b1;
        req_sel   = SW'(sel);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_run(input string name);
        int k = 0;
        while (!out_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(out_valid), 32'(1));
    endtask

    int lat;
    int runs;

    initial begin
        // 1: reset release and boot
        tick_n(3);
        chk("t1_rst_en", 32'(tile_clk_en), 32'(0));
        chk("t1_rst_rstn", 32'(tile_rst_n), 32'(0));
        chk("t1_rst_busy", 32'(busy), 32'(1));
        chk("t1_rst_ready", 32'(req_ready), 32'(0));
        rst = 1'b0;
        for (int i = 0; i < QC; i++) begin
            @(negedge clk);
            chk("t1_boot_en", 32'(tile_clk_en), 32'h1);
            chk("t1_boot_rstn", 32'(tile_rst_n), 32'h0);
        end
        @(negedge clk);
        chk("t1_run_rstn", 32'(tile_rst_n), 32'h1);
        chk("t1_run_valid", 32'(out_valid), 32'(1));
        chk("t1_run_sel", 32'(active_sel), 32'(0));

        // 2: switch 0 -> 2 and its latency
        send_req(2);
        chk("t2_ready_drop", 32'(req_ready), 32'(0));
        chk("t2_drain_en", 32'(tile_clk_en), 32'h1);
        chk("t2_drain_rstn", 32'(tile_rst_n), 32'h0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 4) chk("t2_gate_en", 32'(tile_clk_en), 32'h0);
            if (lat == 5) chk("t2_wake_en", 32'(tile_clk_en), 32'h4);
        end
        chk("t2_latency", 32'(lat), 32'(9));
        chk("t2_sel", 32'(active_sel), 32'(2));
        chk("t2_rstn", 32'(tile_rst_n), 32'h4);

        // 3: no-op requests (same tile, out-of-range tile)
        send_req(1);
        wait_run("t3_run1");
        send_req(1);
        chk("t3_same_busy", 32'(busy), 32'(0));
        chk("t3_same_sel", 32'(active_sel), 32'(1));
        send_req(5);
        chk("t3_range_busy", 32'(busy), 32'(0));
        chk("t3_range_en", 32'(tile_clk_en), 32'h2);
        tick_n(2);
        chk("t3_still_run", 32'(out_valid), 32'(1));
        chk("t3_still_sel", 32'(active_sel), 32'(1));

        // 4: auto-scan wrap 3 -> 0, then external request beats the expiry
        auto_en = 1'b1;
        dwell   = DW'(3);
        send_req(3);
        wait_run("t4_run3");
        chk("t4_sel3", 32'(active_sel), 32'(3));
        runs = 0;
        while (out_valid && runs < 20) begin
            runs++;
            @(negedge clk);
        end
        chk("t4_dwell_cycles", 32'(runs), 32'(3));
        wait_run("t4_wrap_run");
        chk("t4_wrap_sel", 32'(active_sel), 32'(0));
        send_req(3);
        wait_run("t4_back3");
        tick_n(2);
        send_req(1);
        auto_en = 1'b0;
        wait_run("t4_ext_run");
        chk("t4_ext_sel", 32'(active_sel), 32'(1));

        // 5: reset mid-WAKE and mid-DRAIN
        send_req(2);
        tick_n(6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_wake_rst_en", 32'(tile_clk_en), 32'(0));
        chk("t5_wake_rst_sel", 32'(active_sel), 32'(0));
        chk("t5_wake_rst_busy", 32'(busy), 32'(1));
        wait_run("t5_boot1");
        send_req(3);
        tick_n(1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_drain_rst_en", 32'(tile_clk_en), 32'(0));
        chk("t5_drain_rst_sel", 32'(active_sel), 32'(0));
        wait_run("t5_boot2");
        chk("t5_boot2_sel", 32'(active_sel), 32'(0));

        // 6: random stress
        auto_en = 1'b1;
        dwell   = DW'(5);
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            req_valid = ($urandom_range(0, 7) == 0);
            req_sel   = SW'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 299) == 0) dwell = DW'($urandom_range(0, 12));
            rst = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        tick_n(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
